// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux among eight requesters.
// Ports: clk, rst (sync, active-high), req[7:0], lock -> sel[2:0], g_n, grant[7:0], busy.
module mux8_rr_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       lock,
  output logic [2:0] sel,
  output logic       g_n,
  output logic [7:0] grant,
  output logic       busy
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t     state, state_nx;
  logic [2:0] last, last_nx;
  logic [7:0] hcnt, hcnt_nx;
  logic [3:0] gcnt, gcnt_nx;
  logic [2:0] sel_nx;
  logic       g_n_nx;
  logic [7:0] grant_nx;
  logic       busy_nx;

  logic [2:0] idx;
  logic [2:0] cand;
  logic       hit;
  logic       do_load;
  logic       do_gap;

  // Scan last+1 .. last+8 (mod 8); last itself is reached only as the
  // eighth candidate, i.e. when it is the sole requester.
  always_comb begin
    idx  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    hcnt_nx  = hcnt;
    gcnt_nx  = gcnt;
    sel_nx   = sel;
    g_n_nx   = g_n;
    grant_nx = grant;
    busy_nx  = busy;
    do_load  = 1'b0;
    do_gap   = 1'b0;

    unique case (state)
      IDLE: begin
        do_load = hit;
      end
      GRANT: begin
        // Release beats lock; lock beats timeout.
        if (!req[sel]) begin
          do_gap = 1'b1;
        end else if (lock) begin
          hcnt_nx = hcnt;
        end else if (hcnt == 8'd0) begin
          do_gap = 1'b1;
        end else begin
          hcnt_nx = hcnt - 8'd1;
        end
      end
      GAP: begin
        if (gcnt != 4'd0) begin
          gcnt_nx = gcnt - 4'd1;
        end else if (hit) begin
          do_load = 1'b1;
        end else begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (do_load) begin
      state_nx = GRANT;
      sel_nx   = idx;
      last_nx  = idx;
      grant_nx = 8'd1 << idx;
      g_n_nx   = 1'b0;
      busy_nx  = 1'b1;
      hcnt_nx  = HOLD_LOAD;
    end

    if (do_gap) begin
      state_nx = GAP;
      g_n_nx   = 1'b1;
      grant_nx = '0;
      gcnt_nx  = GAP_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 3'd7;
      hcnt  <= '0;
      gcnt  <= '0;
      sel   <= '0;
      g_n   <= 1'b1;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      hcnt  <= hcnt_nx;
      gcnt  <= gcnt_nx;
      sel   <= sel_nx;
      g_n   <= g_n_nx;
      grant <= grant_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Bench for mux8_rr_scheduler: two configurations (4/1 and 1/3)
// driven in parallel, checked every cycle against a grant-ownership model.
module tb_mux8_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       lock;

  logic [2:0] sel0, sel1;
  logic       g_n0, g_n1;
  logic [7:0] grant0, grant1;
  logic       busy0, busy1;

  int n_cmp;
  int n_err;

  // Model: who owns the mux (-1 = nobody), how many counted cycles the
  // owner has had, and how many gap cycles are still to run.
  int owner[2];
  int age[2];
  int gap_left[2];
  int last_m[2];
  int sel_m[2];
  bit gapping[2];

  mux8_rr_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .sel(sel0), .g_n(g_n0), .grant(grant0), .busy(busy0)
  );

  mux8_rr_scheduler #(.HOLD_CYCLES(1), .GAP_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .sel(sel1), .g_n(g_n1), .grant(grant1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic step(input int m, input int hold, input int gap);
    int nx;
    if (rst) begin
      owner[m]   = -1;
      gapping[m] = 1'b0;
      last_m[m]  = 7;
      sel_m[m]   = 0;
      age[m]     = 0;
    end else if (owner[m] >= 0) begin
      if (!req[owner[m]]) begin
        owner[m]    = -1;
        gapping[m]  = 1'b1;
        gap_left[m] = gap;
      end else if (!lock) begin
        if (age[m] == hold) begin
          owner[m]    = -1;
          gapping[m]  = 1'b1;
          gap_left[m] = gap;
        end else begin
          age[m]++;
        end
      end
    end else if (!gapping[m] || gap_left[m] == 1) begin
      nx = pick(last_m[m], req);
      gapping[m] = 1'b0;
      if (nx >= 0) begin
        owner[m]  = nx;
        last_m[m] = nx;
        sel_m[m]  = nx;
        age[m]    = 1;
      end
    end else begin
      gap_left[m]--;
    end
  endtask

  function automatic logic [7:0] exp_grant(input int m);
    logic [7:0] one;
    one = 8'd1;
    return (owner[m] >= 0) ? (one << owner[m]) : 8'd0;
  endfunction

  task automatic compare_all();
    check("g_n0",   32'(g_n0),   32'(owner[0] < 0));
    check("grant0", 32'(grant0), 32'(exp_grant(0)));
    check("sel0",   32'(sel0),   32'(sel_m[0]));
    check("busy0",  32'(busy0),  32'(owner[0] >= 0 || gapping[0]));
    check("g_n1",   32'(g_n1),   32'(owner[1] < 0));
    check("grant1", 32'(grant1), 32'(exp_grant(1)));
    check("sel1",   32'(sel1),   32'(sel_m[1]));
    check("busy1",  32'(busy1),  32'(owner[1] >= 0 || gapping[1]));
  endtask

  task automatic cycle(input logic r, input logic [7:0] q, input logic l);
    rst  = r;
    req  = q;
    lock = l;
    @(posedge clk);
    step(0, 4, 1);
    step(1, 1, 3);
    #1;
    compare_all();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1; age[m] = 0; gap_left[m] = 0;
      last_m[m] = 7; sel_m[m] = 0; gapping[m] = 1'b0;
    end
    rst = 1'b1; req = 8'hFF; lock = 1'b0;

    // Reset with all requests high, then first grant must be index 0.
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    check("rst_g_n", 32'(g_n0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    cycle(1'b0, 8'hFF, 1'b0);
    check("first_grant", 32'(grant0), 32'h01);

    // Full contention: 0..7 then wrap to 0,1.
    for (int i = 0; i < 45; i++) cycle(1'b0, 8'hFF, 1'b0);

    // Single requester 3: 4-on / 1-off.
    cycle(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h08, 1'b0);

    // Early release of 5 with 2 waiting.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h20, 1'b0);
    cycle(1'b0, 8'h24, 1'b0);
    cycle(1'b0, 8'h04, 1'b0);
    check("early_rel", 32'(g_n0), 32'd1);
    cycle(1'b0, 8'h04, 1'b0);
    check("after_gap", 32'(grant0), 32'h04);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h04, 1'b0);

    // Lock on 1 for 10 cycles, expiry, then release while locked.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h02, 1'b1);
    check("lock_hold", 32'(g_n0), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h02, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("lock_rel", 32'(g_n0), 32'd1);
    cycle(1'b0, 8'h00, 1'b0);

    // Reset in the 3rd cycle of a grant to 6.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b0, 8'h40, 1'b0);
    cycle(1'b0, 8'h40, 1'b0);
    cycle(1'b1, 8'h40, 1'b0);
    check("rst_mid", 32'(grant0), 32'h00);
    cycle(1'b0, 8'h41, 1'b0);
    check("rst_restart", 32'(sel0), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h41, 1'b0);

    // Randomized traffic with lock and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] q;
      q = 8'($urandom);
      if ($urandom_range(0, 1) == 1) q = q & 8'($urandom);
      if ($urandom_range(0, 7) == 0) q = 8'h00;
      cycle(($urandom_range(0, 99) == 0), q, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
